// File: rtl/cache_table_ctrl.sv
// Purpose: single-port arbiter for the 2**ADDR_W x 1 cache tag/valid table (lookup, update, full flush).
// Latency: grants and table drive are combinational; lookup data one cycle after lk_gnt; flush = 2**ADDR_W cycles.
// Backpressure: requesters hold *_req until *_gnt; a flush stalls both; updates beat lookups unless
//   CACHE_TABLE_CTRL_STARVE_GUARD_EN is defined, which promotes a lookup after STARVE_LIMIT denials.
module cache_table_ctrl #(
   parameter int unsigned ADDR_W       = 8,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lk_req,
   input  logic [ADDR_W-1:0] lk_addr,
   output logic              lk_gnt,
   output logic              lk_rvalid,
   output logic              lk_rdata,
   input  logic              up_req,
   input  logic [ADDR_W-1:0] up_addr,
   input  logic              up_data,
   output logic              up_gnt,
   input  logic              flush_req,
   output logic              flush_busy,
   output logic              flush_done,
   output logic              tbl_wr,
   output logic [ADDR_W-1:0] tbl_addr,
   output logic              tbl_wd,
   input  logic              tbl_rd
);

   // One spare bit so the end of a flush shows up as a carry rather than a silent wrap.
   localparam int unsigned CNT_W = ADDR_W + 1;

   if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
      $error("cache_table_ctrl: STARVE_LIMIT must be at least 1");
   end

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             lk_rvalid_q, lk_rvalid_d;
   logic             flush_done_q, flush_done_d;
   logic             lk_win, up_win;
   logic             starve_hit;

`ifdef CACHE_TABLE_CTRL_STARVE_GUARD_EN
   localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

   logic [STARVE_W-1:0] starve_q, starve_d;

   assign starve_hit = (starve_q >= STARVE_W'(STARVE_LIMIT));

   // Count consecutive lookup denials caused by an update; any break in that run starts over.
   always_comb begin
      starve_d = starve_q;
      if (state_q != ST_IDLE || flush_req || !lk_req || lk_win) begin
         starve_d = '0;
      end else if (up_win && !starve_hit) begin
         starve_d = starve_q + STARVE_W'(1);
      end
   end

   // Starve counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign starve_hit = 1'b0;
`endif

   assign cnt_inc = cnt_q + CNT_W'(1);

   // Arbitrate the table port: flush, then update, then lookup (a starved lookup jumps the update).
   always_comb begin
      lk_win = 1'b0;
      up_win = 1'b0;
      if (!rst && state_q == ST_IDLE && !flush_req) begin
         if (up_req && !(lk_req && starve_hit)) begin
            up_win = 1'b1;
         end else if (lk_req) begin
            lk_win = 1'b1;
         end
      end
   end

   // Next-state logic: flush walks every address once, then returns to IDLE with a done pulse.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      flush_done_d = 1'b0;
      lk_rvalid_d  = lk_win;
      if (state_q == ST_IDLE) begin
         if (flush_req) begin
            state_d = ST_FLUSH;
            cnt_d   = '0;
         end
      end else begin
         cnt_d = cnt_inc;
         if (cnt_inc[ADDR_W]) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            flush_done_d = 1'b1;
         end
      end
   end

   // State, flush counter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         lk_rvalid_q  <= 1'b0;
         flush_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         lk_rvalid_q  <= lk_rvalid_d;
         flush_done_q <= flush_done_d;
      end
   end

   // Table drive follows the current owner of the port; idle cycles park the address at 0.
   always_comb begin
      tbl_wr   = 1'b0;
      tbl_addr = '0;
      tbl_wd   = 1'b0;
      if (!rst && state_q == ST_FLUSH) begin
         tbl_wr   = 1'b1;
         tbl_addr = cnt_q[ADDR_W-1:0];
      end else if (up_win) begin
         tbl_wr   = 1'b1;
         tbl_addr = up_addr;
         tbl_wd   = up_data;
      end else if (lk_win) begin
         tbl_addr = lk_addr;
      end
   end

   assign lk_gnt     = lk_win;
   assign up_gnt     = up_win;
   assign lk_rvalid  = lk_rvalid_q & ~rst;
   assign lk_rdata   = lk_rvalid_q & ~rst & tbl_rd;
   assign flush_busy = ~rst & (state_q == ST_FLUSH);
   assign flush_done = flush_done_q & ~rst;

endmodule

// File: doc/cache_table_ctrl.md
Name: cache_table_ctrl

Overview:
Controller and arbiter for the 256-entry x 1-bit cache tag/valid bit table. It shares the table's single port between three users: a lookup requester (read), an update requester (write), and a flush sequencer that clears every entry. It drives the table's write-enable, address and write-data directly, and returns lookup results with fixed latency.

Parameters:
ADDR_W, 8, table address width; table depth is 2**ADDR_W
STARVE_LIMIT, 4, consecutive lookup denials before the lookup is promoted (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
lk_req  in  1  lookup request, level; held until granted
lk_addr  in  ADDR_W  lookup address
lk_gnt  out  1  lookup granted this cycle (combinational)
lk_rvalid  out  1  lookup data valid, registered
lk_rdata  out  1  lookup bit; equals tbl_rd when lk_rvalid=1, else 0
up_req  in  1  update request, level; held until granted
up_addr  in  ADDR_W  update address
up_data  in  1  bit to write
up_gnt  out  1  update granted this cycle (combinational)
flush_req  in  1  start full-table clear
flush_busy  out  1  flush in progress
flush_done  out  1  one-cycle pulse when the flush completes
tbl_wr  out  1  table write enable
tbl_addr  out  ADDR_W  table address
tbl_wd  out  1  table write data
tbl_rd  in  1  table registered read data; valid the cycle after a read with tbl_wr=0

Behaviour:
- Reset: state IDLE, flush counter 0, starve counter 0, lk_rvalid 0, flush_done 0. Every output reads 0 while rst=1.
- Two states: IDLE and FLUSH, held in a state register.
- Table drive in IDLE is combinational from the current grant:
  - update granted: tbl_wr=1, tbl_addr=up_addr, tbl_wd=up_data
  - lookup granted: tbl_wr=0, tbl_addr=lk_addr, tbl_wd=0
  - no grant: tbl_wr=0, tbl_addr=0, tbl_wd=0
- IDLE priority: flush_req > up_req > lk_req.
  - If flush_req=1: no grants, next state FLUSH, counter cleared to 0.
  - Otherwise at most one grant per cycle.
- Lookup latency: lk_gnt in cycle N gives lk_rvalid=1 and lk_rdata=tbl_rd in cycle N+1. Back-to-back lookups give one result per cycle.
- Update takes effect at the edge ending its grant cycle. A lookup granted the next cycle to the same address returns the new value; no forwarding is required.
- FLUSH:
  - Each cycle: tbl_wr=1, tbl_addr=counter, tbl_wd=0; counter increments.
  - After the write to address 2**ADDR_W-1, next state IDLE and flush_done=1 for one cycle.
  - Flush length is exactly 2**ADDR_W cycles; flush_busy=1 throughout.
- During FLUSH:
  - lk_gnt=0 and up_gnt=0; requesters keep waiting.
  - flush_req is ignored; there is no restart.
  - lk_rvalid is 0, except the cycle right after a lookup granted in the last IDLE cycle, which is impossible because flush_req suppresses grants.
- Counter wrap: the counter is ADDR_W+1 bits wide; FLUSH terminates on the terminal count and never wraps silently.
- flush_req in the flush_done cycle (state IDLE) starts a new flush.
- Reset mid-flush: immediate return to IDLE, counter 0, no flush_done. The table contents are cleared by the table's own reset.

Optional Feature:
CACHE_TABLE_CTRL_STARVE_GUARD_EN
- Defined:
  - A starve counter increments each IDLE cycle with lk_req=1 and lk_gnt=0 caused by up_req.
  - When the counter reaches STARVE_LIMIT, the next contended cycle grants the lookup over the update.
  - The counter clears on lk_gnt, when lk_req=0, or on entering FLUSH.
  - flush_req still wins over everything.
- Undefined: update strictly beats lookup; no counter logic is present.

Test Plan:
- Reset, then update addr 0x12 data 1, then lookup 0x12 -> up_gnt in cycle 1, lk_gnt in cycle 2, lk_rvalid=1 with lk_rdata=1 in cycle 3.
- lk_req and up_req asserted together on different addresses -> up_gnt first, lk_gnt next cycle; tbl_wr=1 then 0.
- Write 1 to addr 0x00, 0x80 and 0xFF, pulse flush_req, hold lk_req -> flush_busy for 256 cycles, tbl_addr steps 0x00..0xFF with tbl_wd=0, flush_done pulse, then lookups of all three addresses return 0.
- Assert rst at flush counter 0x40 -> outputs 0 at once; after release state is IDLE, flush_busy=0, no flush_done.
- With CACHE_TABLE_CTRL_STARVE_GUARD_EN and STARVE_LIMIT=4, hold up_req and lk_req continuously -> four up_gnt cycles, then one lk_gnt, pattern repeats; without the macro, lk_gnt never asserts.
- flush_req asserted during a flush at counter 0x10 -> ignored; flush_done occurs exactly 256 cycles after the original start.
